// File: rtl/ram_burst_controller.sv
// Burst bus master for a single-port synchronous RAM.
// Accepts read/write burst commands over valid/ready and streams write
// beats in and read beats out. It sequences the RAM strobes and the shared
// tristate data bus, with one RAM access per beat.
module ram_burst_controller #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    // write data channel
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    // read data channel
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    // status
    output logic                  busy,
    // RAM side
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    typedef enum logic [2:0] {
        ST_IDLE,      // waiting for a command
        ST_WR_WAIT,   // waiting for the next write beat, RAM deselected
        ST_WR_DO,     // one-cycle RAM write strobe
        ST_RD_ISSUE,  // one-cycle RAM read strobe, sample at the closing edge
        ST_RD_HOLD    // read beat held in rd_data until consumed
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;         // current beat address, drives ram_addr
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;           // beats remaining after the current one
    logic [DATA_WIDTH-1:0] wbeat_q, wbeat_d;       // latched write beat for the bus
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  more_beats;

    // Handshake and status outputs decoded from the current state.
    assign cmd_ready = (state_q == ST_IDLE) && rst_n;
    assign wr_ready  = (state_q == ST_WR_WAIT);
    assign busy      = (state_q != ST_IDLE);

    assign more_beats = (cnt_q != '0);

    // Registered RAM strobes and read channel.
    assign ram_addr = addr_q;
    assign ram_cs   = cs_q;
    assign ram_we   = we_q;
    assign ram_oe   = oe_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // The bus is driven only while the write strobe is up, so it can never
    // collide with the RAM, which drives only when we=0 and oe=1.
    assign ram_data = we_q ? wbeat_q : {DATA_WIDTH{1'bz}};

    // Next-state and next-output logic. The strobes for a RAM access are
    // computed on the transition into the access state, so the registered
    // strobes line up with ST_WR_DO / ST_RD_ISSUE.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; a missing assignment here would infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wbeat_d    = wbeat_q;
        cs_d       = 1'b0;
        we_d       = 1'b0;
        oe_d       = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d = cmd_addr;
                    cnt_d  = cmd_len;
                    if (cmd_write) begin
                        state_d = ST_WR_WAIT;
                    end else begin
                        state_d = ST_RD_ISSUE;
                        cs_d    = 1'b1;
                        oe_d    = 1'b1;
                    end
                end
            end

            ST_WR_WAIT: begin
                if (wr_valid) begin
                    wbeat_d = wr_data;
                    state_d = ST_WR_DO;
                    cs_d    = 1'b1;
                    we_d    = 1'b1;
                end
            end

            ST_WR_DO: begin
                // The RAM captures the beat at the edge that leaves this state.
                if (more_beats) begin
                    state_d = ST_WR_WAIT;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    cnt_d   = cnt_q - LEN_WIDTH'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD_ISSUE: begin
                rd_data_d  = ram_data;
                rd_valid_d = 1'b1;
                state_d    = ST_RD_HOLD;
            end

            ST_RD_HOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (more_beats) begin
                        state_d = ST_RD_ISSUE;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        cnt_d   = cnt_q - LEN_WIDTH'(1);
                        cs_d    = 1'b1;
                        oe_d    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // independent of the order in which the simulator runs the processes.
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and RAM strobe registers. Reset drops every strobe, so a
    // write already strobed at the reset edge completes and nothing follows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            wbeat_q    <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            oe_q       <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wbeat_q    <= wbeat_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            oe_q       <= oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_ram_burst_controller.sv
// Self-checking bench for ram_burst_controller: a behavioural RAM on the
// tristate bus, a reference memory image updated per burst, a table of
// directed bursts, a mid-read reset sequence and randomized bursts.
module tb_ram_burst_controller;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int LW    = 4;
    localparam int NB    = 1 << LW;
    localparam int DEPTH = 1 << AW;
    localparam int TMO   = 200;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [LW-1:0] cmd_len   = '0;
    logic          wr_valid  = 1'b0;
    logic [DW-1:0] wr_data   = '0;
    logic          rd_ready  = 1'b0;
    logic          cmd_ready, wr_ready, rd_valid, busy;
    logic          ram_cs, ram_we, ram_oe;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    int n_cmp    = 0;
    int n_fail   = 0;
    int cs_total = 0;
    int bus_viol = 0;

    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [AW-1:0] wlog_a [$];
    logic [DW-1:0] wlog_d [$];

    typedef struct {
        string                name;
        bit                   write;
        logic [AW-1:0]        addr;
        logic [LW-1:0]        len;
        logic [NB-1:0][DW-1:0] data;   // write beats, or expected read beats
        int                   gap;
        int                   stall_beat;
        int                   stall_cycles;
        bit                   poke;
    } op_t;

    always #5 clk = ~clk;

    ram_burst_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe)
    );

    // Behavioural RAM: synchronous write, output driven while selected for read.
    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            ram_mem[ram_addr] <= ram_data;
            wlog_a.push_back(ram_addr);
            wlog_d.push_back(ram_data);
        end
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_mem[ram_addr] : {DW{1'bz}};

    // Bus monitor: counts RAM accesses and any cycle where both sides could drive.
    always @(negedge clk) begin
        if (ram_cs) cs_total <= cs_total + 1;
        if ((ram_we && ram_oe) || (ram_we && !ram_cs)) bus_viol <= bus_viol + 1;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(0));
        check({tag, "_wr_ready"},  32'(wr_ready),  32'(0));
        check({tag, "_rd_valid"},  32'(rd_valid),  32'(0));
        check({tag, "_rd_data"},   32'(rd_data),   32'(0));
        check({tag, "_busy"},      32'(busy),      32'(0));
        check({tag, "_strobes"},   32'({ram_cs, ram_we, ram_oe}), 32'(0));
        check({tag, "_ram_addr"},  32'(ram_addr),  32'(0));
    endtask

    function automatic op_t mk(input string name, input bit write, input logic [AW-1:0] addr,
                               input logic [LW-1:0] len, input logic [NB*DW-1:0] data,
                               input int gap, input int sbeat, input int scyc, input bit poke);
        op_t v;
        v.name = name;  v.write = write;  v.addr = addr;  v.len = len;
        v.data = data;  v.gap = gap;  v.stall_beat = sbeat;
        v.stall_cycles = scyc;  v.poke = poke;
        return v;
    endfunction

    // Offer a command at a negedge; returns at the negedge after acceptance.
    task automatic send_cmd(input op_t v);
        int t = 0;
        cmd_valid = 1'b1;  cmd_write = v.write;  cmd_addr = v.addr;  cmd_len = v.len;
        while (!cmd_ready && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check({v.name, "_cmd_accept"}, 32'(cmd_ready), 32'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_op(input op_t v);
        int            nb  = int'(v.len) + 1;
        int            cs0 = cs_total;
        int            wl0 = wlog_a.size();
        int            t;
        logic [AW-1:0] a;
        send_cmd(v);
        for (int i = 0; i < nb; i++) begin
            a = v.addr + AW'(i);
            if (v.write) begin
                for (int g = 0; g < v.gap; g++) begin
                    if (v.poke) begin
                        cmd_valid = 1'b1;  cmd_write = 1'b0;  cmd_addr = ~v.addr;
                        check($sformatf("%s_busy_cmd_ready%0d", v.name, i), 32'(cmd_ready), 32'(0));
                    end
                    @(negedge clk);
                    cmd_valid = 1'b0;
                    check($sformatf("%s_gap_cs%0d", v.name, i), 32'(ram_cs), 32'(0));
                end
                wr_valid = 1'b1;
                wr_data  = v.data[i];
                t = 0;
                while (!wr_ready && t < TMO) begin
                    @(negedge clk);
                    t++;
                end
                check($sformatf("%s_wr_ready%0d", v.name, i), 32'(wr_ready), 32'(1));
                @(negedge clk);
                wr_valid = 1'b0;
                check($sformatf("%s_wr_strobe%0d", v.name, i), 32'({ram_cs, ram_we, ram_oe}), 32'(3'b110));
                check($sformatf("%s_wr_addr%0d", v.name, i), 32'(ram_addr), 32'(a));
                check($sformatf("%s_wr_bus%0d", v.name, i), 32'(ram_data), 32'(v.data[i]));
            end else begin
                check($sformatf("%s_rd_strobe%0d", v.name, i), 32'({ram_cs, ram_we, ram_oe}), 32'(3'b101));
                check($sformatf("%s_rd_addr%0d", v.name, i), 32'(ram_addr), 32'(a));
                t = 0;
                while (!rd_valid && t < TMO) begin
                    @(negedge clk);
                    t++;
                end
                check($sformatf("%s_rd_valid%0d", v.name, i), 32'(rd_valid), 32'(1));
                if (i == v.stall_beat) begin
                    for (int s = 0; s < v.stall_cycles; s++) begin
                        @(negedge clk);
                        check($sformatf("%s_stall_valid%0d", v.name, s), 32'(rd_valid), 32'(1));
                        check($sformatf("%s_stall_data%0d", v.name, s), 32'(rd_data), 32'(v.data[i]));
                        check($sformatf("%s_stall_cs%0d", v.name, s), 32'(ram_cs), 32'(0));
                    end
                end
                check($sformatf("%s_rd_data%0d", v.name, i), 32'(rd_data), 32'(v.data[i]));
                rd_ready = 1'b1;
                @(negedge clk);
                rd_ready = 1'b0;
            end
        end
        t = 0;
        while (busy && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check({v.name, "_idle"}, 32'(busy), 32'(0));
        check({v.name, "_accesses"}, 32'(cs_total - cs0), 32'(nb));
        if (v.write) begin
            check({v.name, "_ram_writes"}, 32'(wlog_a.size() - wl0), 32'(nb));
            for (int i = 0; i < nb; i++) begin
                if (wl0 + i < wlog_a.size()) begin
                    a = v.addr + AW'(i);
                    check($sformatf("%s_ram_wr%0d", v.name, i),
                          32'({wlog_a[wl0 + i], wlog_d[wl0 + i]}), 32'({a, v.data[i]}));
                end
            end
        end
    endtask

    // Run a burst and fold its writes into the reference memory image.
    task automatic do_op(input op_t v);
        run_op(v);
        if (v.write) begin
            for (int i = 0; i <= int'(v.len); i++) ref_mem[v.addr + AW'(i)] = v.data[i];
        end
    endtask

    initial begin
        op_t tbl [8];
        op_t v;
        int  t;
        int  c0;

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge clk);
        check("por_cmd_ready_after", 32'(cmd_ready), 32'(1));

        // wr_valid while idle must not start anything.
        c0 = cs_total;
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stray_wr_ready%0d", k), 32'(wr_ready), 32'(0));
            check($sformatf("stray_busy%0d", k), 32'(busy), 32'(0));
        end
        wr_valid = 1'b0;
        check("stray_accesses", 32'(cs_total - c0), 32'(0));

        // Fill the whole RAM so every later read has a known expectation.
        for (int b = 0; b < DEPTH / NB; b++) begin
            v = mk("fill", 1'b1, AW'(b * NB), LW'(NB - 1), '0, 0, 0, 0, 1'b0);
            for (int i = 0; i < NB; i++) v.data[i] = DW'($urandom);
            do_op(v);
        end

        // Directed bursts: {name, write, addr, len, beats, gap, stall beat, stall cycles, poke}.
        tbl[0] = mk("t1_wr",    1'b1, 10'h005, 4'd0, 128'hA5,       0, 0, 0, 1'b0);
        tbl[1] = mk("t1_rd",    1'b0, 10'h005, 4'd0, 128'hA5,       0, 0, 0, 1'b0);
        tbl[2] = mk("t2_wr",    1'b1, 10'h3FE, 4'd3, 128'h44332211, 0, 0, 0, 1'b0);
        tbl[3] = mk("t2_rd",    1'b0, 10'h3FE, 4'd3, 128'h44332211, 0, 0, 0, 1'b0);
        tbl[4] = mk("t3_stall", 1'b0, 10'h3FE, 4'd3, 128'h44332211, 0, 1, 5, 1'b0);
        tbl[5] = mk("t4_gaps",  1'b1, 10'h100, 4'd3, 128'h8D7C6B5A, 3, 0, 0, 1'b1);
        tbl[6] = mk("t4_rd",    1'b0, 10'h100, 4'd3, 128'h8D7C6B5A, 0, 0, 0, 1'b0);
        tbl[7] = mk("wrap_rd",  1'b0, 10'h3FF, 4'd1, 128'h3322,     0, 0, 0, 1'b0);
        for (int k = 0; k < 8; k++) do_op(tbl[k]);

        // Reset for one cycle while beat 2 of a 4-beat read is pending.
        v = mk("t5_rd", 1'b0, 10'h3FE, 4'd3, 128'h44332211, 0, 0, 0, 1'b0);
        send_cmd(v);
        t = 0;
        while (!rd_valid && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("t5_beat1_data", 32'(rd_data), 32'(8'h11));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        t = 0;
        while (!rd_valid && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("t5_beat2_pending", 32'(rd_valid), 32'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("t5_rst");
        rst_n = 1'b1;
        c0 = cs_total;
        @(negedge clk);
        check("t5_cmd_ready_after", 32'(cmd_ready), 32'(1));
        repeat (3) @(negedge clk);
        check("t5_no_access_after", 32'(cs_total - c0), 32'(0));
        check("t5_rd_valid_after", 32'(rd_valid), 32'(0));
        do_op(mk("t5_after_rd", 1'b0, 10'h005, 4'd0, 128'hA5, 0, 0, 0, 1'b0));

        // Randomized bursts against the reference memory image.
        for (int k = 0; k < 40; k++) begin
            v = mk($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                   LW'($urandom_range(0, NB - 1)), '0, int'($urandom_range(0, 2)),
                   int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < NB; i++) v.data[i] = v.write ? DW'($urandom) : ref_mem[v.addr + AW'(i)];
            do_op(v);
        end

        @(negedge clk);
        check("bus_contention", 32'(bus_viol), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
